crib_loader: RTL and testbench

//   Upstream feeder for the bombe. The operator enters a crib from switches and a push-key as
//   (plaintext, ciphertext) letter pairs; pairs are validated and stored in an on-chip buffer.
//   On go, the buffer is streamed to the bombe over a valid/ready handshake, one pair per beat.

---
 rtl/crib_loader.sv | 214 +++++++++++++++++++++
 tb/tb_crib_loader.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crib_loader.sv
// Crib loader: debounced letter entry into a pair buffer, then streams the
// stored (plaintext, ciphertext) pairs to the bombe over valid/ready.
module crib_loader #(
   parameter int DEPTH        = 16,
   parameter int CHAR_W       = 8,
   parameter int DEBOUNCE_CNT = 50000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [CHAR_W-1:0]        char_in,
   input  logic                     key_press,
   input  logic                     go,
   input  logic                     clear,
   output logic [CHAR_W-1:0]        out_plain,
   output logic [CHAR_W-1:0]        out_cipher,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_last,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     error,
   output logic [1:0]               state_out
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int DB_W  = $clog2(DEBOUNCE_CNT + 1);

   localparam logic [CHAR_W-1:0] MAX_LETTER = CHAR_W'(25);
   localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);
   localparam logic [DB_W-1:0]   DB_MAX     = DB_W'(DEBOUNCE_CNT - 1);

   typedef enum logic [1:0] {
      LOAD_P = 2'd0,
      LOAD_C = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t                  state, state_next;
   logic [CNT_W-1:0]        count_next;
   logic [PTR_W-1:0]        rd_ptr, rd_ptr_next;
   logic [CHAR_W-1:0]       held, held_next;
   logic                    error_next;
   logic                    valid_next, last_next;
   logic [CHAR_W-1:0]       plain_next, cipher_next;
   logic                    wr_en;

   logic [2*CHAR_W-1:0]     mem [DEPTH];

   logic                    key_s1, key_s2, key_prev, key_db;
   logic [DB_W-1:0]         db_cnt;
   logic                    db_hit, accept;
   logic                    go_s1, go_s2, go_s3, go_edge;

   // The debounced level only changes after the synced level has held still
   // for DEBOUNCE_CNT cycles; a rising debounced level is the accept pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         key_s1   <= 1'b0;
         key_s2   <= 1'b0;
         key_prev <= 1'b0;
         key_db   <= 1'b0;
         db_cnt   <= '0;
      end else begin
         key_s1 <= key_press;
         key_s2 <= key_s1;
         if (key_s2 != key_prev) begin
            key_prev <= key_s2;
            db_cnt   <= '0;
         end else begin
            if (db_cnt != DB_MAX) begin
               db_cnt <= db_cnt + DB_W'(1);
            end
            if (db_hit) begin
               key_db <= key_prev;
            end
         end
      end
   end

   assign db_hit = (key_s2 == key_prev) && (db_cnt == DB_MAX);
   assign accept = db_hit && key_prev && !key_db;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         go_s1 <= 1'b0;
         go_s2 <= 1'b0;
         go_s3 <= 1'b0;
      end else begin
         go_s1 <= go;
         go_s2 <= go_s1;
         go_s3 <= go_s2;
      end
   end

   assign go_edge = go_s2 && !go_s3;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[count[PTR_W-1:0]] <= {held, char_in};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= LOAD_P;
         count      <= '0;
         rd_ptr     <= '0;
         held       <= '0;
         error      <= 1'b0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         out_plain  <= '0;
         out_cipher <= '0;
      end else begin
         state      <= state_next;
         count      <= count_next;
         rd_ptr     <= rd_ptr_next;
         held       <= held_next;
         error      <= error_next;
         out_valid  <= valid_next;
         out_last   <= last_next;
         out_plain  <= plain_next;
         out_cipher <= cipher_next;
      end
   end

   // Output pair registers only reload on stream start or a handshake, so the
   // presented pair stays put while the bombe stalls.
   always_comb begin
      state_next  = state;
      count_next  = count;
      rd_ptr_next = rd_ptr;
      held_next   = held;
      error_next  = error;
      valid_next  = out_valid;
      last_next   = out_last;
      plain_next  = out_plain;
      cipher_next = out_cipher;
      wr_en       = 1'b0;

      if (clear) begin
         state_next  = LOAD_P;
         count_next  = '0;
         rd_ptr_next = '0;
         error_next  = 1'b0;
         valid_next  = 1'b0;
         last_next   = 1'b0;
      end else begin
         case (state)
            LOAD_P: begin
               if (go_edge) begin
                  if (count != '0) begin
                     state_next                = STREAM;
                     rd_ptr_next               = '0;
                     {plain_next, cipher_next} = mem[0];
                     valid_next                = 1'b1;
                     last_next                 = (count == CNT_W'(1));
                  end
               end else if (accept && !full) begin
                  if (char_in > MAX_LETTER) begin
                     error_next = 1'b1;
                  end else begin
                     held_next  = char_in;
                     error_next = 1'b0;
                     state_next = LOAD_C;
                  end
               end
            end
            LOAD_C: begin
               if (accept) begin
                  state_next = LOAD_P;
                  if (char_in > MAX_LETTER || char_in == held) begin
                     error_next = 1'b1;
                     held_next  = '0;
                  end else if (!full) begin
                     wr_en      = 1'b1;
                     count_next = count + CNT_W'(1);
                     error_next = 1'b0;
                  end
               end
            end
            STREAM: begin
               if (out_valid && out_ready) begin
                  if (out_last) begin
                     state_next = DONE;
                     valid_next = 1'b0;
                     last_next  = 1'b0;
                  end else begin
                     rd_ptr_next               = rd_ptr + PTR_W'(1);
                     {plain_next, cipher_next} = mem[rd_ptr_next];
                     last_next = ((CNT_W'(rd_ptr_next) + CNT_W'(1)) == count);
                  end
               end
            end
            DONE: begin
               if (go_edge) begin
                  state_next                = STREAM;
                  rd_ptr_next               = '0;
                  {plain_next, cipher_next} = mem[0];
                  valid_next                = 1'b1;
                  last_next                 = (count == CNT_W'(1));
               end
            end
            default: state_next = LOAD_P;
         endcase
      end
   end

   assign full      = (count == DEPTH_C);
   assign state_out = state;

endmodule

// File: tb/tb_crib_loader.sv
// Bench for crib_loader: letters entered through the bouncy key, stream
// beats checked against a scoreboard of the pairs the bench stored.
module tb_crib_loader;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] char_in = '0;
   logic       key_press = 1'b0;
   logic       go = 1'b0;
   logic       clear = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] out_plain, out_cipher;
   logic       out_valid, out_last, full, error;
   logic [4:0] count;
   logic [1:0] state_out;

   int n_cmp = 0;
   int n_fail = 0;

   logic [15:0] model_buf[$];
   logic [16:0] exp_q[$];

   always #5 clk = ~clk;

   crib_loader #(.DEPTH(16), .CHAR_W(8), .DEBOUNCE_CNT(4)) dut (
      .clk(clk), .reset(reset), .char_in(char_in), .key_press(key_press),
      .go(go), .clear(clear), .out_plain(out_plain), .out_cipher(out_cipher),
      .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .count(count), .full(full), .error(error), .state_out(state_out)
   );

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input logic [7:0] ch);
      char_in   = ch;
      key_press = 1'b1;
      wait_neg(12);
      key_press = 1'b0;
      wait_neg(12);
   endtask

   task automatic enter_pair(input logic [7:0] p, input logic [7:0] c);
      press(p);
      press(c);
      model_buf.push_back({p, c});
   endtask

   // Expected beats are queued at the go pulse: {last, plain, cipher}.
   task automatic pulse_go();
      go = 1'b1;
      wait_neg(1);
      go = 1'b0;
      exp_q.delete();
      foreach (model_buf[i]) begin
         exp_q.push_back({(i == model_buf.size() - 1), model_buf[i]});
      end
   endtask

   task automatic drain(input bit toggle, input int limit);
      int beats = 0;
      int budget = 0;
      bit rdy = 1'b1;
      out_ready = 1'b0;
      while (exp_q.size() > 0 && beats < limit && budget < 400) begin
         @(negedge clk);
         budget++;
         if (out_valid) begin
            n_cmp++;
            if ({out_last, out_plain, out_cipher} !== exp_q[0]) begin
               n_fail++;
               $display("[TB] FAIL beat%0d: got last=%0d %0d/%0d expected last=%0d %0d/%0d",
                        beats, out_last, out_plain, out_cipher,
                        exp_q[0][16], exp_q[0][15:8], exp_q[0][7:0]);
            end
            rdy       = toggle ? ~rdy : 1'b1;
            out_ready = rdy;
            if (rdy) begin
               void'(exp_q.pop_front());
               beats++;
            end
         end
      end
      if (budget >= 400) begin
         n_cmp++;
         n_fail++;
         $display("[TB] FAIL stream_timeout: got %0d beats expected %0d more", beats, exp_q.size());
      end
   endtask

   task automatic test_reset();
      wait_neg(3);
      n_cmp++;
      if ({state_out, count, out_valid, out_last, error, full, out_plain, out_cipher} !== 27'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_state: got st=%0d cnt=%0d v=%0d l=%0d e=%0d f=%0d p=%0d c=%0d expected all 0",
                  state_out, count, out_valid, out_last, error, full, out_plain, out_cipher);
      end
      reset = 1'b1;
      wait_neg(2);
   endtask

   task automatic test_debounce();
      char_in = 8'd7;
      for (int i = 0; i < 5; i++) begin
         key_press = 1'b1;
         wait_neg(2);
         key_press = 1'b0;
         wait_neg(2);
      end
      n_cmp++;
      if (state_out !== 2'd0) begin
         n_fail++;
         $display("[TB] FAIL bounce_no_accept: got state %0d expected 0", state_out);
      end
      key_press = 1'b1;
      wait_neg(12);
      n_cmp++;
      if (state_out !== 2'd1) begin
         n_fail++;
         $display("[TB] FAIL held_accept: got state %0d expected 1", state_out);
      end
      wait_neg(12);
      n_cmp++;
      if (state_out !== 2'd1 || count !== 5'd0) begin
         n_fail++;
         $display("[TB] FAIL single_accept: got state %0d count %0d expected 1 0", state_out, count);
      end
      key_press = 1'b0;
      wait_neg(12);
      press(8'd19);
      model_buf.push_back({8'd7, 8'd19});
      n_cmp++;
      if (state_out !== 2'd0 || count !== 5'd1 || error !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL first_pair: got st=%0d cnt=%0d err=%0d expected 0 1 0", state_out, count, error);
      end
   endtask

   task automatic test_stream();
      enter_pair(8'd4, 8'd2);
      enter_pair(8'd0, 8'd25);
      pulse_go();
      drain(1'b0, 1000);
      wait_neg(1);
      n_cmp++;
      if (out_valid !== 1'b0 || state_out !== 2'd3 || count !== 5'd3) begin
         n_fail++;
         $display("[TB] FAIL stream_done: got v=%0d st=%0d cnt=%0d expected 0 3 3", out_valid, state_out, count);
      end
   endtask

   task automatic test_errors();
      clear = 1'b1;
      wait_neg(1);
      clear = 1'b0;
      model_buf.delete();
      press(8'd5);
      press(8'd5);
      n_cmp++;
      if (error !== 1'b1 || count !== 5'd0 || state_out !== 2'd0) begin
         n_fail++;
         $display("[TB] FAIL self_map: got e=%0d cnt=%0d st=%0d expected 1 0 0", error, count, state_out);
      end
      press(8'd30);
      n_cmp++;
      if (error !== 1'b1 || state_out !== 2'd0) begin
         n_fail++;
         $display("[TB] FAIL bad_plain: got e=%0d st=%0d expected 1 0", error, state_out);
      end
      press(8'd3);
      n_cmp++;
      if (error !== 1'b0 || state_out !== 2'd1) begin
         n_fail++;
         $display("[TB] FAIL error_clears: got e=%0d st=%0d expected 0 1", error, state_out);
      end
      press(8'd26);
      n_cmp++;
      if (error !== 1'b1 || state_out !== 2'd0 || count !== 5'd0) begin
         n_fail++;
         $display("[TB] FAIL bad_cipher: got e=%0d st=%0d cnt=%0d expected 1 0 0", error, state_out, count);
      end
   endtask

   task automatic test_full();
      logic [7:0] p, c;
      clear = 1'b1;
      wait_neg(1);
      clear = 1'b0;
      model_buf.delete();
      for (int i = 0; i < 16; i++) begin
         p = 8'($urandom_range(0, 25));
         c = 8'((int'(p) + int'($urandom_range(1, 25))) % 26);
         enter_pair(p, c);
      end
      n_cmp++;
      if (full !== 1'b1 || count !== 5'd16) begin
         n_fail++;
         $display("[TB] FAIL fill: got full=%0d cnt=%0d expected 1 16", full, count);
      end
      press(8'd6);
      n_cmp++;
      if (count !== 5'd16 || state_out !== 2'd0 || error !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL press_when_full: got cnt=%0d st=%0d e=%0d expected 16 0 0", count, state_out, error);
      end
      pulse_go();
      drain(1'b1, 1000);
      wait_neg(1);
      n_cmp++;
      if (out_valid !== 1'b0 || state_out !== 2'd3) begin
         n_fail++;
         $display("[TB] FAIL full_done: got v=%0d st=%0d expected 0 3", out_valid, state_out);
      end
   endtask

   task automatic test_back_to_back();
      pulse_go();
      drain(1'b0, 1000);
      wait_neg(1);
      n_cmp++;
      if (out_valid !== 1'b0 || state_out !== 2'd3 || count !== 5'd16) begin
         n_fail++;
         $display("[TB] FAIL replay_done: got v=%0d st=%0d cnt=%0d expected 0 3 16", out_valid, state_out, count);
      end
      clear = 1'b1;
      go    = 1'b1;
      wait_neg(1);
      clear = 1'b0;
      model_buf.delete();
      n_cmp++;
      if (state_out !== 2'd0 || count !== 5'd0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL clear_now: got st=%0d cnt=%0d v=%0d expected 0 0 0", state_out, count, out_valid);
      end
      wait_neg(1);
      go = 1'b0;
      wait_neg(4);
      n_cmp++;
      if (state_out !== 2'd0 || count !== 5'd0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL clear_over_go: got st=%0d cnt=%0d v=%0d expected 0 0 0", state_out, count, out_valid);
      end
   endtask

   task automatic test_reset_mid_stream();
      enter_pair(8'd1, 8'd2);
      enter_pair(8'd3, 8'd4);
      enter_pair(8'd5, 8'd6);
      enter_pair(8'd7, 8'd8);
      pulse_go();
      drain(1'b0, 2);
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || {out_plain, out_cipher} !== {8'd5, 8'd6}) begin
         n_fail++;
         $display("[TB] FAIL third_beat: got v=%0d %0d/%0d expected 1 5/6", out_valid, out_plain, out_cipher);
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if ({out_valid, out_last, out_plain, out_cipher, state_out, count, error, full} !== 27'd0) begin
         n_fail++;
         $display("[TB] FAIL async_reset: got v=%0d l=%0d %0d/%0d st=%0d cnt=%0d expected all 0",
                  out_valid, out_last, out_plain, out_cipher, state_out, count);
      end
      model_buf.delete();
      exp_q.delete();
      wait_neg(2);
      reset = 1'b1;
      wait_neg(3);
      n_cmp++;
      if (state_out !== 2'd0 || count !== 5'd0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL after_reset: got st=%0d cnt=%0d v=%0d expected 0 0 0", state_out, count, out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_stream();
      test_errors();
      test_full();
      test_back_to_back();
      test_reset_mid_stream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
